// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: turns byte-addressed RV32I accesses into a word-wide
// request/acknowledge transaction, with lane steering, load extension and fault detection.
module mem_access_unit #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              load_valid,
    output logic              fault,
    output logic              timeout_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              to_q;

    logic              req, is_wr, illegal, misalign;
    logic [3:0]        be_new;
    logic [31:0]       wd_new;
    logic [31:0]       ext;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              latch_en, finish, tmo_hit;
    logic              unused_addr;

    assign unused_addr = ^addr[31:ADDR_W+2];

    assign req   = MemRead | MemWrite;
    assign is_wr = MemWrite;  // both asserted is a write

    always_comb begin
        unique case (funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = is_wr;
            default:                illegal = 1'b1;
        endcase
        misalign = (funct3[1:0] == 2'b01 && addr[0]) ||
                   (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    end

    always_comb begin
        be_new = 4'b1111;
        wd_new = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                be_new = 4'b0001 << addr[1:0];
                wd_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new = addr[1] ? 4'b1100 : 4'b0011;
                wd_new = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        if (!is_wr) be_new = 4'b0000;
    end

    always_comb begin
        byte_sel = mem_rdata[8*off_q +: 8];
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (f3_q)
            3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext = {24'b0, byte_sel};
            3'b101:  ext = {16'b0, half_sel};
            default: ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        fault       = 1'b0;
        load_valid  = 1'b0;
        timeout_err = 1'b0;
        latch_en    = 1'b0;
        finish      = 1'b0;
        tmo_hit     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                // Combinational outputs are gated so everything reads 0 while reset is held.
                if (req && rst) begin
                    if (illegal || misalign) begin
                        fault = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        latch_en = 1'b1;
                        state_d  = StReq;
                    end
                end
            end
            StReq: begin
                stall = rst;
                cnt_d = cnt_q + 8'd1;
                if (mem_ack) begin
                    finish  = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == LastCnt) begin
                    finish  = 1'b1;
                    tmo_hit = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                load_valid  = ~we_q;
                timeout_err = to_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                we_q    <= is_wr;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
                addr_q  <= addr[ADDR_W+1:2];
                be_q    <= be_new;
                wdata_q <= wd_new;
            end
            if (finish) begin
                to_q <= tmo_hit;
                if (!we_q) rdata_q <= tmo_hit ? 32'd0 : ext;
            end
        end
    end

    assign mem_req   = (state_q == StReq);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// compared against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int Tmo = 4;

    logic        clk, rst;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, load_valid, fault, timeout_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd_model = 32'd0;

    mem_access_unit #(.ADDR_W(12), .TIMEOUT(Tmo)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .load_valid(load_valid),
        .fault(fault), .timeout_err(timeout_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_fault(input bit wr, input bit [2:0] f3, input bit [31:0] a);
        bit legal;
        int sz;
        legal = (f3 == 0 || f3 == 1 || f3 == 2) || (!wr && (f3 == 4 || f3 == 5));
        sz = 1 << f3[1:0];
        return !legal || (a % sz != 0);
    endfunction

    function automatic bit [31:0] m_be(input bit wr, input bit [2:0] f3, input bit [31:0] a);
        int o;
        o = a % 4;
        if (!wr) return 0;
        if (f3 == 0) return 32'd1 << o;
        if (f3 == 1) return 32'd3 << o;
        return 32'd15;
    endfunction

    function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] d);
        if (f3 == 0) return (d & 32'hFF) * 32'h01010101;
        if (f3 == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic bit [31:0] m_rdata(input bit [2:0] f3, input bit [31:0] a,
                                          input bit [31:0] w);
        bit [31:0] b, h;
        int o;
        o = a % 4;
        b = (w >> (8 * o)) & 32'hFF;
        h = (w >> (16 * (o / 2))) & 32'hFFFF;
        case (f3)
            0: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            1: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            4: return b;
            5: return h;
            default: return w;
        endcase
    endfunction

    // One pipeline access; the EX/MEM inputs are held while stalled and through DONE.
    task automatic access(input bit rd, input bit wr, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] d, input int ack_dly, input bit [31:0] rw);
        bit w, is_fault, done, timed;
        int k;
        w = wr;
        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = d;
        mem_ack = 1'($urandom % 2);
        mem_rdata = $urandom;
        #1;
        is_fault = m_fault(w, f3, a);
        check("fault_idle", fault, is_fault);
        check("stall_idle", stall, !is_fault);
        check("req_idle", mem_req, 0);
        if (is_fault) begin
            @(posedge clk); #2;
            MemRead = 0; MemWrite = 0; mem_ack = 0;
            #1;
            check("fault_clear", fault, 0);
            check("req_after_fault", mem_req, 0);
            check("rdata_hold", rdata, rd_model);
            return;
        end
        @(posedge clk); #2;
        done = 0; timed = 0; k = 0;
        while (!done) begin
            mem_ack = (k == ack_dly);
            mem_rdata = (k == ack_dly) ? rw : $urandom;
            #1;
            check("mem_req", mem_req, 1);
            check("stall_req", stall, 1);
            check("mem_we", mem_we, w);
            check("mem_addr", mem_addr, a[13:2]);
            check("mem_be", mem_be, m_be(w, f3, a));
            if (w) check("mem_wdata", mem_wdata, m_wdata(f3, d));
            check("tmo_early", timeout_err, 0);
            if (k == ack_dly) done = 1;
            else if (k == Tmo - 1) begin done = 1; timed = 1; end
            @(posedge clk); #2;
            k++;
        end
        mem_ack = 1'($urandom % 2);
        #1;
        check("stall_done", stall, 0);
        check("req_done", mem_req, 0);
        check("load_valid", load_valid, !w);
        check("timeout_err", timeout_err, timed);
        if (!w) rd_model = timed ? 32'd0 : m_rdata(f3, a, rw);
        check("rdata", rdata, rd_model);
        @(posedge clk); #2;
        MemRead = 0; MemWrite = 0; mem_ack = 0;
        #1;
        check("no_reissue", mem_req, 0);
        check("lv_pulse", load_valid, 0);
        check("tmo_pulse", timeout_err, 0);
        check("stall_idle2", stall, 0);
        check("rdata_hold", rdata, rd_model);
    endtask

    initial begin
        rst = 0; MemRead = 0; MemWrite = 0; funct3 = 0; addr = 0; wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_req", mem_req, 0);
        check("rst_rdata", rdata, 0);
        check("rst_lv", load_valid, 0);
        @(posedge clk); #2;
        rst = 1;
        @(posedge clk); #2;

        access(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 1, 0);
        access(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0);
        access(0, 1, 3'b001, 32'h102, 32'h0000BEEF, 0, 0);
        access(1, 0, 3'b000, 32'h201, 0, 0, 32'h12348056);
        access(1, 0, 3'b100, 32'h201, 0, 2, 32'h12348056);
        access(1, 0, 3'b101, 32'h202, 0, 0, 32'h12348056);
        access(1, 0, 3'b010, 32'h102, 0, 0, 32'h0);
        access(1, 0, 3'b011, 32'h100, 0, 0, 32'h0);
        access(1, 0, 3'b010, 32'h400, 0, 99, 32'hCAFEF00D);
        access(1, 0, 3'b010, 32'h404, 0, Tmo - 1, 32'hCAFEF00D);
        access(1, 1, 3'b010, 32'h408, 32'h11223344, 0, 0);
        access(0, 1, 3'b100, 32'h400, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            bit r;
            r = 1'($urandom % 2);
            access(r, !r || ($urandom % 8 == 0), 3'($urandom), $urandom, $urandom,
                   int'($urandom % 6), $urandom);
        end

        // Asynchronous reset in the middle of a request.
        MemRead = 1; MemWrite = 0; funct3 = 3'b010; addr = 32'h300; mem_ack = 0;
        @(posedge clk); #2;
        #1;
        check("pre_rst_req", mem_req, 1);
        rst = 0;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_stall", stall, 0);
        check("arst_rdata", rdata, 0);
        check("arst_be", mem_be, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_fault", fault, 0);
        rd_model = 0;
        MemRead = 0;
        @(posedge clk); #2;
        rst = 1;
        @(posedge clk); #2;
        access(1, 0, 3'b001, 32'h30E, 0, 1, 32'h8001_7FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage responder for the MemRead/MemWrite/funct3 controls decoded for loads and stores in the pipelined RV32I core.
- Converts a byte-addressed RV32I load/store into a word-wide request/acknowledge transaction to data memory.
- Generates byte enables, sign/zero-extends load data, detects misaligned/illegal accesses, and holds the pipeline via stall until memory acknowledges.

Parameters:
ADDR_W, 12, word-address width driven to data memory (mem_addr = addr[ADDR_W+1:2])
TIMEOUT, 255, max cycles waiting for mem_ack before abort; 8-bit counter, legal range 1..255

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
MemRead  in  1  load request from EX/MEM register
MemWrite  in  1  store request from EX/MEM register
funct3  in  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  hold IF..MEM stages
rdata  out  32  extended load result
load_valid  out  1  one-cycle pulse, rdata valid
fault  out  1  one-cycle pulse, misaligned or illegal funct3
timeout_err  out  1  one-cycle pulse, memory did not acknowledge
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  word address
mem_be  out  4  byte enables (writes only; 4'b0000 on reads)
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory acknowledge, one cycle
mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0; all outputs 0, including rdata and mem_req. Reset mid-transaction drops mem_req immediately and discards the access.
- FSM states: IDLE, REQ, DONE.
- IDLE, request present (MemRead|MemWrite): both asserted is treated as a write.
  - Alignment rules: half requires addr[0]=0; word requires addr[1:0]=00.
  - Illegal funct3: 011, 110, 111; also 100/101 on a write.
  - Faulty access: fault=1 this cycle, no memory access, stall=0, stay IDLE.
  - Legal access: stall=1 combinationally this cycle; latch addr, funct3, we, lane data, be; go to REQ.
- REQ:
  - mem_req=1, stall=1, mem_* driven from latched values and stable until ack.
  - Counter increments each cycle.
  - mem_ack=1: drop mem_req next cycle; on read, register the extended result into rdata; go to DONE.
  - Counter reaches TIMEOUT without ack: timeout_err=1, rdata=0 on reads, go to DONE.
  - mem_ack in the same cycle the counter hits TIMEOUT: ack wins, no timeout_err.
- DONE:
  - stall=0 so the pipeline advances on this edge; load_valid=1 if read (also after timeout).
  - Unconditionally return to IDLE; inputs sampled in DONE are ignored, so the same instruction is not re-issued.
- Latency: aligned access with mem_ack at first REQ cycle = 3 cycles (IDLE→REQ→DONE); stall high for 2 cycles.
- Store lanes:
  - sb: be=4'b0001<<addr[1:0], wdata[7:0] replicated x4.
  - sh: be=addr[1]?1100:0011, wdata[15:0] replicated x2.
  - sw: be=1111.
- Load extract:
  - Byte lane selected by addr[1:0]; half by addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- rdata holds its last value except when updated by a read completion.
- mem_ack outside REQ is ignored.

Test Plan:
- sw addr=0x104, wdata=0xDEADBEEF, ack after 2 cycles -> mem_addr=0x041, be=1111, mem_wdata=0xDEADBEEF, stall high 3 cycles, no load_valid.
- sb addr=0x103, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5; sh addr=0x102 -> be=1100.
- lb addr=0x201, mem_rdata=0x12348056 -> rdata=0x00000080? No: byte1=0x80 -> rdata=0xFFFFFF80; lbu same -> 0x00000080; lhu addr=0x202 -> 0x00001234; load_valid single pulse in DONE.
- lw addr=0x102 -> fault pulse, mem_req never asserts, stall=0; funct3=011 read at aligned addr -> fault.
- TIMEOUT=4, lw with no mem_ack -> mem_req high 4 cycles, timeout_err pulse, rdata=0, load_valid pulse; ack on 4th cycle instead -> no timeout_err.
- rst driven low mid-REQ -> mem_req, stall, and all outputs 0 asynchronously; after release, FSM in IDLE and next request serviced normally.
